// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
//   Shared constants for the scoreboarded register file:
//     RADDR_W  - register address width (5 bits, MIPS-style)
//     NREG_DEF - register count used by the MIPS core (32)
//     ZERO_REG - index of the hard-wired zero register
//   Also holds a small helper used by both the storage and the scoreboard to
//   test whether an address is the zero register.
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int unsigned RADDR_W = 5;
  localparam int          NREG_DEF = 32;
  localparam logic [RADDR_W-1:0] ZERO_REG = '0;

  // True when the address names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [RADDR_W-1:0] addr);
    return (addr == ZERO_REG);
  endfunction

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_sb_scoreboard
//   Pending-write scoreboard for the register file. One pend bit per register
//   marks an outstanding long-latency write (load). The bit is set when the
//   load issues and cleared when its write-back arrives; stall is raised when
//   an instruction wants to read a register that is still pending.
//
//   Optional feature (macro REGFILE_SB_BYPASS_EN): a pend bit that is being
//   cleared by the write-back of this very cycle does not raise stall, because
//   the top level forwards the write-back data to the read port.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   clrn         : synchronous active-low reset
//   iss_e/iss_rn : issue of a long-latency write to register iss_rn
//   we/wn        : write-back strobe and register (clears pend)
//   rna/rnb      : read addresses of ports A and B
//   ua/ub        : the instruction actually uses port A / port B
//   pend         : scoreboard vector, bit 0 is constant 0
//   stall        : read-after-pending-write hazard, forced 0 during reset
// -----------------------------------------------------------------------------
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               iss_e,
  input  logic [RADDR_W-1:0] iss_rn,
  input  logic               we,
  input  logic [RADDR_W-1:0] wn,
  input  logic [RADDR_W-1:0] rna,
  input  logic [RADDR_W-1:0] rnb,
  input  logic               ua,
  input  logic               ub,
  output logic [NREG-1:0]    pend,
  output logic               stall
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Per-register next-state. The set term is OR-ed after the clear so that a
  // load issuing to the same register that is being written back this edge
  // keeps the bit pending (the new load is still outstanding).
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    if (gi == 0) begin : g_zero
      always_comb begin
        pend_d[gi] = 1'b0;
      end
    end else begin : g_bit
      logic set_hit;
      logic clr_hit;
      always_comb begin
        set_hit    = iss_e && (iss_rn == RADDR_W'(gi));
        clr_hit    = we && (wn == RADDR_W'(gi));
        pend_d[gi] = set_hit || (pend_q[gi] && !clr_hit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

  // Hazard lookup. Addresses beyond NREG have no scoreboard entry.
  logic pend_a;
  logic pend_b;
  logic haz_a;
  logic haz_b;

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    if (int'(rna) < NREG) pend_a = pend_q[rna];
    if (int'(rnb) < NREG) pend_b = pend_q[rnb];
`ifdef REGFILE_SB_BYPASS_EN
    // The write-back of this cycle is forwarded to the read port, so the
    // register it clears is no longer a hazard.
    haz_a = pend_a && !(we && (wn == rna));
    haz_b = pend_b && !(we && (wn == rnb));
`else
    haz_a = pend_a;
    haz_b = pend_b;
`endif
  end

  always_comb begin
    stall = 1'b0;
    if (clrn) begin
      stall = (ua && haz_a) || (ub && haz_b);
    end
  end

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Two-read / one-write register file with a load scoreboard. Register 0 is
//   hard-wired to zero. Reads are combinational; writes and scoreboard updates
//   happen on the rising edge of clk. A synchronous active-low reset (clrn)
//   clears every register and every pend bit and ignores we/iss_e on that edge.
//
//   Optional feature (macro REGFILE_SB_BYPASS_EN): a write-back to the register
//   being read is forwarded to qa/qb in the same cycle, and the scoreboard does
//   not stall on the register that write-back is releasing. Without the macro
//   reads return stored values only (write-to-read latency of one edge).
//
// Ports
//   clk, clrn     : clock, synchronous active-low reset
//   rna, rnb      : read addresses (5 bits)
//   ua, ub        : port A / port B used by the current instruction
//   qa, qb        : read data (WIDTH bits)
//   we, wn, d     : write-back strobe, register, data
//   iss_e, iss_rn : issue of a long-latency write to iss_rn
//   stall         : read-after-pending-write hazard
//   pend          : scoreboard vector, one bit per register
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = NREG_DEF
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [RADDR_W-1:0] rna,
  input  logic [RADDR_W-1:0] rnb,
  input  logic               ua,
  input  logic               ub,
  output logic [WIDTH-1:0]   qa,
  output logic [WIDTH-1:0]   qb,
  input  logic               we,
  input  logic [RADDR_W-1:0] wn,
  input  logic [WIDTH-1:0]   d,
  input  logic               iss_e,
  input  logic [RADDR_W-1:0] iss_rn,
  output logic               stall,
  output logic [NREG-1:0]    pend
);

  // ---------------------------------------------------------------------------
  // Storage. Kept in flops rather than block RAM: reads are asynchronous and
  // the whole array must clear on reset.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      // Writes to register 0 are discarded.
      always_comb begin
        regs_d[gi] = '0;
      end
    end else begin : g_word
      always_comb begin
        regs_d[gi] = regs_q[gi];
        if (we && (wn == RADDR_W'(gi))) begin
          regs_d[gi] = d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!clrn) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (!is_zero_reg(rna) && (int'(rna) < NREG)) rd_a = regs_q[rna];
    if (!is_zero_reg(rnb) && (int'(rnb) < NREG)) rd_b = regs_q[rnb];
  end

`ifdef REGFILE_SB_BYPASS_EN
  // Forward the write-back data when it targets the register being read.
  // Register 0 is excluded because that write is discarded.
  logic byp_a;
  logic byp_b;

  always_comb begin
    byp_a = we && !is_zero_reg(wn) && (wn == rna);
    byp_b = we && !is_zero_reg(wn) && (wn == rnb);
    qa    = byp_a ? d : rd_a;
    qb    = byp_b ? d : rd_b;
  end
`else
  always_comb begin
    qa = rd_a;
    qb = rd_b;
  end
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  regfile_sb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk    (clk),
    .clrn   (clrn),
    .iss_e  (iss_e),
    .iss_rn (iss_rn),
    .we     (we),
    .wn     (wn),
    .rna    (rna),
    .rnb    (rnb),
    .ua     (ua),
    .ub     (ub),
    .pend   (pend),
    .stall  (stall)
  );

endmodule : regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, register count (addresses 5 bits; NREG fixed at 32 in the MIPS core).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clrn, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have ports rna and rnb, input, 5 each: read addresses for ports A and B.
REQ-006 SHALL have ports ua and ub, input, 1 each: the instruction uses port A or port B.
REQ-007 SHALL have ports qa and qb, output, WIDTH each: read data.
REQ-008 SHALL have ports we (input, 1), wn (input, 5) and d (input, WIDTH): the write-back port.
REQ-009 SHALL have ports iss_e (input, 1) and iss_rn (input, 5): issue of a long-latency write (load) to iss_rn.
REQ-010 SHALL have port stall, output, 1: read-after-pending-write hazard.
REQ-011 SHALL have port pend, output, NREG: scoreboard vector, one bit per register.

Function
REQ-012 SHALL drive qa and qb combinationally from rna and rnb; reading address 0 SHALL always return 0.
REQ-013 SHALL write d into register wn at the rising edge when clrn=1, we=1 and wn!=0; a write to wn=0 SHALL be discarded.
REQ-014 SHALL set pend[iss_rn] at the edge when clrn=1, iss_e=1 and iss_rn!=0.
REQ-015 SHALL clear pend[wn] at the edge when clrn=1 and we=1.
REQ-016 When a set and a clear hit the same register on the same edge, the set SHALL win and pend stays 1.
REQ-017 When a set and a clear hit different registers on the same edge, both SHALL take effect.
REQ-018 pend[0] SHALL be constant 0.
REQ-019 SHALL compute stall combinationally as (ua AND hazard on rna) OR (ub AND hazard on rnb), where a hazard exists when the pend bit of the addressed register is 1, subject to REQ-025.
REQ-020 SHALL force stall to 0 while clrn=0.
REQ-021 SHALL have a write-to-read latency of one edge without bypass and zero cycles with bypass (REQ-024).

Reset
REQ-022 SHALL clear all registers and all pend bits to 0 at a rising edge with clrn=0; we and iss_e SHALL be ignored on that edge.
REQ-023 A reset edge arriving while loads are pending SHALL discard the outstanding pend bits; a later we to those registers SHALL write normally with no pend effect.

Configuration
REQ-024 With macro REGFILE_SB_BYPASS_EN defined, when we=1, wn!=0 and wn equals rna (or rnb), qa (or qb) SHALL return d in the same cycle.
REQ-025 With REGFILE_SB_BYPASS_EN defined, a pend bit being cleared by the current write-back SHALL NOT raise stall.
REQ-026 Without REGFILE_SB_BYPASS_EN, qa and qb SHALL return the stored values only, and stall SHALL follow the current pend bits without exception.

Structure
REQ-027 The shared package SHALL hold the register-address width constant (5), the value NREG=32 and the zero-register index constant.
REQ-028 The block SHALL have one sub-module, regfile_sb_scoreboard, which holds the pend vector and computes stall; the storage array and read muxing SHALL stay in the top level.

Verification
REQ-029 Reset then read: hold clrn=0 for 1 edge, release, set rna=5 and rnb=0 -> qa=0, qb=0, pend=0, stall=0.
REQ-030 Write then read: apply we=1, wn=3, d=32'hDEADBEEF -> after the edge, rna=3 gives qa=32'hDEADBEEF; we=1, wn=0, d=32'h1234 leaves qa at rna=0 equal to 0.
REQ-031 Load-use hazard: iss_e=1, iss_rn=8 at edge N; at N+1 set rna=8, ua=1 -> stall=1 and pend[8]=1; with ua=0 -> stall=0.
REQ-032 Write-back releasing the hazard: pend[8]=1, we=1, wn=8, d=32'h55 with rna=8, ua=1 -> with BYPASS_EN, qa=32'h55 and stall=0 in the same cycle; without it, stall=1 that cycle, then stall=0 and qa=32'h55 after the edge.
REQ-033 Simultaneous set and clear: iss_e=1, iss_rn=9 and we=1, wn=9 on the same edge -> pend[9]=1; with iss_rn=9 and wn=10 -> pend[9]=1 and pend[10]=0.
REQ-034 Reset mid-operation: pend[4]=1 and r4=32'h77, then one edge with clrn=0 -> pend=0, r4 reads 0, stall=0; a following we=1, wn=4, d=1 writes normally.
